// File: rtl/fifo_mem_prog.sv
// rtl/fifo_mem_prog.sv - parametrised single-clock FIFO with fill level, threshold and sticky errors
// Optional macro FIFO_MEM_FWFT_EN selects first-word fall-through reads; default is a 1-cycle registered read.
module fifo_mem_prog #(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W:0]   thresh_cfg,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W:0]   fifo_level,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_threshold,
  output logic              fifo_overflow,
  output logic              fifo_underflow
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [DATA_W-1:0] r_data_out;
  logic              r_overflow;
  logic              r_underflow;

  logic [ADDR_W:0]   w_level;
  logic              w_full;
  logic              w_empty;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_ovf_set;
  logic              w_udf_set;
  logic [ADDR_W-1:0] w_wr_idx;
  logic [ADDR_W-1:0] w_rd_idx;

  // The wrap bit makes the pointer difference the occupancy, so full and empty stay distinct.
  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_level == DEPTH_L);
  assign w_empty   = (w_level == '0);
  assign w_rd_acc  = rd & ~w_empty;
  assign w_wr_acc  = wr & (~w_full | rd);
  assign w_ovf_set = wr & w_full & ~rd;
  assign w_udf_set = rd & w_empty;
  assign w_wr_idx  = r_wr_ptr[ADDR_W-1:0];
  assign w_rd_idx  = r_rd_ptr[ADDR_W-1:0];

  // Storage is deliberately not reset; writes are blocked while rst_n is low.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_acc) begin
      r_mem[w_wr_idx] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_data_out  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= r_mem[w_rd_idx];
      end
      // A new error event on the same edge as clr_err takes priority.
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_udf_set) begin
        r_underflow <= 1'b1;
      end else if (clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

`ifdef FIFO_MEM_FWFT_EN
  // Head entry is shown directly; r_data_out keeps the last popped word for the empty case.
  assign data_out = w_empty ? r_data_out : r_mem[w_rd_idx];
`else
  assign data_out = r_data_out;
`endif

  assign fifo_level     = w_level;
  assign fifo_full      = w_full;
  assign fifo_empty     = w_empty;
  assign fifo_threshold = (w_level >= thresh_cfg);
  assign fifo_overflow  = r_overflow;
  assign fifo_underflow = r_underflow;

endmodule

// File: tb/tb_fifo_mem_prog.sv
// tb/tb_fifo_mem_prog.sv - self-checking bench for fifo_mem_prog against a queue-based reference model
module tb_fifo_mem_prog;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [4:0] thresh_cfg = 5'd0;
  logic [7:0] data_out;
  logic [4:0] fifo_level;
  logic       fifo_full, fifo_empty, fifo_threshold, fifo_overflow, fifo_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_q[$];
  logic [7:0] m_reg = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  always #5 clk = ~clk;

  fifo_mem_prog #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .data_in(data_in),
    .thresh_cfg(thresh_cfg), .clr_err(clr_err), .data_out(data_out),
    .fifo_level(fifo_level), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_threshold(fifo_threshold), .fifo_overflow(fifo_overflow),
    .fifo_underflow(fifo_underflow)
  );

  function automatic logic [7:0] exp_dout();
`ifdef FIFO_MEM_FWFT_EN
    return (m_q.size() != 0) ? m_q[0] : m_reg;
`else
    return m_reg;
`endif
  endfunction

  // Drive one cycle of inputs, advance the reference model at the edge, settle 1 time unit.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c, input logic rn);
    int lvl;
    wr = w; rd = r; data_in = d; clr_err = c; rst_n = rn;
    @(posedge clk);
    lvl = m_q.size();
    if (!rn) begin
      m_q.delete();
      m_reg = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      if (w && lvl == DEPTH && !r) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      if (r && lvl == 0) m_udf = 1'b1;
      else if (c) m_udf = 1'b0;
      if (r && lvl != 0) m_reg = m_q.pop_front();
      if (w && (lvl < DEPTH || r)) m_q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    thresh_cfg = 5'd3;
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    n_tests++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_tests++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", fifo_empty); end
    n_tests++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", fifo_full); end
    n_tests++; if (fifo_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", fifo_overflow); end
    n_tests++; if (fifo_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_udf: got %b want 0", fifo_underflow); end
    n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %0h want 0", data_out); end
    n_tests++; if (fifo_threshold !== 1'b0) begin n_fail++; $display("FAIL reset_thr3: got %b want 0", fifo_threshold); end
    thresh_cfg = 5'd0;
    #1;
    n_tests++; if (fifo_threshold !== 1'b1) begin n_fail++; $display("FAIL reset_thr0: got %b want 1", fifo_threshold); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    n_tests++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_nowrite: got %0d want 0", fifo_level); end
  endtask

  task automatic test_fill();
    thresh_cfg = 5'd12;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0, 1'b1);
      n_tests++; if (fifo_level !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_level: got %0d want %0d", fifo_level, i + 1); end
      n_tests++; if (fifo_threshold !== (i + 1 >= 12)) begin n_fail++; $display("FAIL fill_thr: got %b want %b at level %0d", fifo_threshold, (i + 1 >= 12), i + 1); end
      n_tests++; if (fifo_full !== (i + 1 == 16)) begin n_fail++; $display("FAIL fill_full: got %b want %b", fifo_full, (i + 1 == 16)); end
    end
    step(1'b1, 1'b0, 8'hAA, 1'b0, 1'b1);
    n_tests++; if (fifo_overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf: got %b want 1", fifo_overflow); end
    n_tests++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL fill_drop_level: got %0d want 16", fifo_level); end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    n_tests++; if (fifo_overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_clr: got %b want 0", fifo_overflow); end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
`ifndef FIFO_MEM_FWFT_EN
      n_tests++; if (data_out !== 8'(i)) begin n_fail++; $display("FAIL fill_order: got %0h want %0h", data_out, i); end
`endif
      n_tests++; if (data_out !== exp_dout()) begin n_fail++; $display("FAIL fill_read: got %0h want %0h", data_out, exp_dout()); end
    end
    n_tests++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL fill_drained: got %b want 1", fifo_empty); end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    n_tests++; if (fifo_underflow !== 1'b1) begin n_fail++; $display("FAIL udf_set: got %b want 1", fifo_underflow); end
    n_tests++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL udf_level: got %0d want 0", fifo_level); end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    n_tests++; if (fifo_underflow !== 1'b0) begin n_fail++; $display("FAIL udf_clr: got %b want 0", fifo_underflow); end
    step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    n_tests++; if (fifo_underflow !== 1'b1) begin n_fail++; $display("FAIL udf_set_wins: got %b want 1", fifo_underflow); end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b1);
      n_tests++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL sim_level: got %0d want 16", fifo_level); end
      n_tests++; if (fifo_overflow !== 1'b0) begin n_fail++; $display("FAIL sim_ovf: got %b want 0", fifo_overflow); end
      n_tests++; if (data_out !== exp_dout()) begin n_fail++; $display("FAIL sim_data: got %0h want %0h", data_out, exp_dout()); end
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
      n_tests++; if (data_out !== exp_dout()) begin n_fail++; $display("FAIL sim_drain: got %0h want %0h", data_out, exp_dout()); end
    end
    step(1'b1, 1'b1, 8'h3C, 1'b0, 1'b1);
    n_tests++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL sim_empty_level: got %0d want 1", fifo_level); end
    n_tests++; if (fifo_underflow !== 1'b1) begin n_fail++; $display("FAIL sim_empty_udf: got %b want 1", fifo_underflow); end
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    n_tests++; if (data_out !== 8'h3C) begin n_fail++; $display("FAIL sim_empty_data: got %0h want 3c", data_out); end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic test_stream();
    logic [7:0] pat;
    pat = 8'hF0;
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) begin
        step(1'b1, 1'b0, pat, 1'b0, 1'b1);
        pat = pat + 8'd1;
      end else begin
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
      end
      n_tests++; if (fifo_level !== ((i % 2 == 0) ? 5'd1 : 5'd0)) begin n_fail++; $display("FAIL stream_level: got %0d at cycle %0d", fifo_level, i); end
      n_tests++; if (data_out !== exp_dout()) begin n_fail++; $display("FAIL stream_data: got %0h want %0h", data_out, exp_dout()); end
      n_tests++; if ({fifo_overflow, fifo_underflow} !== 2'b00) begin n_fail++; $display("FAIL stream_flags: got %b%b want 00", fifo_overflow, fifo_underflow); end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b1);
    n_tests++; if (fifo_level !== 5'd7) begin n_fail++; $display("FAIL midrst_pre: got %0d want 7", fifo_level); end
    step(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    n_tests++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL midrst_level: got %0d want 0", fifo_level); end
    n_tests++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL midrst_empty: got %b want 1", fifo_empty); end
    step(1'b1, 1'b0, 8'h5C, 1'b0, 1'b1);
`ifdef FIFO_MEM_FWFT_EN
    n_tests++; if (data_out !== 8'h5C) begin n_fail++; $display("FAIL midrst_fwft: got %0h want 5c", data_out); end
`endif
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
`ifndef FIFO_MEM_FWFT_EN
    n_tests++; if (data_out !== 8'h5C) begin n_fail++; $display("FAIL midrst_first: got %0h want 5c", data_out); end
`endif
    n_tests++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL midrst_drained: got %b want 1", fifo_empty); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      thresh_cfg = 5'($urandom_range(0, 20));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) != 0));
      n_tests++; if (fifo_level !== 5'(m_q.size())) begin n_fail++; $display("FAIL rand_level: got %0d want %0d", fifo_level, m_q.size()); end
      n_tests++; if (fifo_full !== (m_q.size() == DEPTH)) begin n_fail++; $display("FAIL rand_full: got %b", fifo_full); end
      n_tests++; if (fifo_empty !== (m_q.size() == 0)) begin n_fail++; $display("FAIL rand_empty: got %b", fifo_empty); end
      n_tests++; if (fifo_threshold !== (m_q.size() >= int'(thresh_cfg))) begin n_fail++; $display("FAIL rand_thr: got %b level %0d cfg %0d", fifo_threshold, m_q.size(), thresh_cfg); end
      n_tests++; if (fifo_overflow !== m_ovf) begin n_fail++; $display("FAIL rand_ovf: got %b want %b", fifo_overflow, m_ovf); end
      n_tests++; if (fifo_underflow !== m_udf) begin n_fail++; $display("FAIL rand_udf: got %b want %b", fifo_underflow, m_udf); end
      n_tests++; if (data_out !== exp_dout()) begin n_fail++; $display("FAIL rand_data: got %0h want %0h", data_out, exp_dout()); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_underflow();
    test_simultaneous();
    test_stream();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_mem_prog.md
Name: fifo_mem_prog

Overview:
Parametrised synchronous single-clock FIFO. Next generation of the 8-bit fifo_mem.
- Adds generic width and depth, an exposed fill level and a programmable threshold.
- Overflow/underflow flags are sticky and cleared by software.
- Sits between a byte/word producer and consumer in the same clock domain; status flags feed the control logic and the interrupt logic.

Parameters:
- DATA_W, 8, data word width in bits.
- DEPTH, 16, number of entries; power of two, at least 4.
- ADDR_W, $clog2(DEPTH), pointer index width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- wr  in  1  write request.
- rd  in  1  read request.
- data_in  in  DATA_W  write data.
- thresh_cfg  in  ADDR_W+1  threshold level, 0..DEPTH.
- clr_err  in  1  clears the sticky error flags.
- data_out  out  DATA_W  read data.
- fifo_level  out  ADDR_W+1  current occupancy, 0..DEPTH.
- fifo_full  out  1  fifo_level == DEPTH.
- fifo_empty  out  1  fifo_level == 0.
- fifo_threshold  out  1  fifo_level >= thresh_cfg.
- fifo_overflow  out  1  sticky: a write was dropped.
- fifo_underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst_n low at a clock edge):
  - Write and read pointers go to 0; fifo_level 0; fifo_empty 1; fifo_full 0.
  - fifo_overflow and fifo_underflow go to 0; data_out goes to 0.
  - fifo_threshold becomes (0 >= thresh_cfg).
  - Memory contents are not cleared.
  - Reset in mid-stream discards all queued data.
- Pointers are ADDR_W+1 bits; the MSB is the wrap bit. fifo_level = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
- Accept rules, per clock edge:
  - rd_acc = rd & !fifo_empty.
  - wr_acc = wr & (!fifo_full | rd).
- Full with wr & rd: both are accepted and the level is unchanged.
- Empty with wr & rd: the write is accepted, the read is rejected, and fifo_underflow is set.
- Write: on wr_acc, mem[wr_ptr[ADDR_W-1:0]] <= data_in and wr_ptr increments.
- Read (default mode):
  - On rd_acc, data_out <= mem[rd_ptr[ADDR_W-1:0]] and rd_ptr increments.
  - data_out holds its value otherwise.
  - Read latency is 1 cycle.
  - A word written at edge N can be read at edge N+1 and appears on data_out after edge N+1.
- Status outputs:
  - fifo_level, fifo_full and fifo_empty derive from the registered pointers and change only at the edge that accepts an operation.
  - fifo_threshold is combinational from fifo_level and thresh_cfg.
  - thresh_cfg = 0 makes fifo_threshold always 1; thresh_cfg > DEPTH makes it always 0.
- Errors:
  - wr while full without rd: the write is dropped and fifo_overflow <= 1.
  - rd while empty: fifo_underflow <= 1.
  - Both flags hold until clr_err or reset.
  - clr_err clears both flags at the next edge. If a new error event occurs on the same edge, the set wins.
- Pointer wrap-around is seamless; there is no bubble at the DEPTH-1 -> 0 index transition.

Optional Feature:
Macro FIFO_MEM_FWFT_EN.
- Defined (first-word fall-through):
  - data_out = mem[rd_ptr] combinationally whenever fifo_empty == 0; rd pops the head entry.
  - Read latency is 0: a word written at edge N is visible on data_out after edge N.
  - While empty, data_out holds the last word presented, or 0 after reset.
- Undefined: the registered 1-cycle read described under Behaviour.
- Flags, level and error behaviour are identical in both modes.

Test Plan:
- Reset check: hold rst_n = 0 with wr = 1, rd = 1 for 2 cycles.
  - Required: level 0, empty 1, full 0, overflow 0, underflow 0, data_out 0; nothing is written.
- Fill: write 0x00..0x0F, thresh_cfg = 12.
  - fifo_threshold rises on the edge where the level reaches 12.
  - full = 1 at level 16.
  - A 17th write (0xAA) is dropped and sets fifo_overflow.
  - Reading all 16 words returns 0x00..0x0F in order.
- Underflow: rd on an empty FIFO sets fifo_underflow = 1 and level stays 0.
  - A clr_err pulse clears it.
  - clr_err together with another rd while empty leaves fifo_underflow = 1.
- Simultaneous: with full, wr & rd for 20 cycles.
  - Level stays 16, no overflow, and data order is preserved across pointer wrap.
  - With empty, wr & rd: level becomes 1 and underflow is set.
- Wrap/stream: 100 cycles of alternating write/read of an incrementing pattern.
  - Data matches the scoreboard, level toggles 0/1, and no flags are set.
- Mid-operation reset: at level 7, assert rst_n = 0 for 1 cycle.
  - Level 0, empty 1.
  - The next written word 0x5C is the first word read out.
  - Repeat with FIFO_MEM_FWFT_EN defined: 0x5C appears on data_out with no rd.
